// File: rtl/vga_dither_out.sv
// VGA output stage: narrows core colour to the DAC width by truncate, round,
// ordered dither or colour bars, blanks outside the active area, delays sync.
module vga_dither_chan #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 4
) (
   input  logic [1:0]       mode,
   input  logic [IN_W-1:0]  pix,
   input  logic [IN_W-1:0]  dith,
   input  logic             bar,
   output logic [OUT_W-1:0] q
);
   localparam int D = IN_W - OUT_W;
   localparam logic [IN_W-1:0] HALF = IN_W'(1 << (D - 1));

   logic [IN_W-1:0] off;
   logic [IN_W:0]   sum;

   // One extra sum bit catches overflow so bright inputs clamp instead of wrapping
   always_comb begin
      off = (mode == 2'd1) ? HALF : dith;
      sum = {1'b0, pix} + {1'b0, off};
      q   = '0;
      case (mode)
         2'd0:       q = pix[IN_W-1:D];
         2'd1, 2'd2: q = sum[IN_W] ? '1 : sum[IN_W-1:D];
         default:    q = {OUT_W{bar}};
      endcase
   end
endmodule

module vga_dither_out #(
   parameter int IN_W            = 8,
   parameter int OUT_W           = 4,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int H_START         = 144,
   parameter int H_ACTIVE        = 640,
   parameter int V_START         = 35,
   parameter int V_ACTIVE        = 480
) (
   input  logic             CLK_25MHZ,
   input  logic             RESET_N,
   input  logic [1:0]       MODE,
   input  logic             IN_HSYNC,
   input  logic             IN_VSYNC,
   input  logic [IN_W-1:0]  IN_RED,
   input  logic [IN_W-1:0]  IN_GREEN,
   input  logic [IN_W-1:0]  IN_BLUE,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic [OUT_W-1:0] VGA_R,
   output logic [OUT_W-1:0] VGA_G,
   output logic [OUT_W-1:0] VGA_B
);
   localparam int D = IN_W - OUT_W;
   localparam logic INACT = (SYNC_ACTIVE_LOW != 0);
   localparam logic [11:0] H_LO = 12'(H_START);
   localparam logic [11:0] H_HI = 12'(H_START + H_ACTIVE);
   localparam logic [10:0] V_LO = 11'(V_START);
   localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);
   localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
   // Bayer entry k lives in nibble k, k = {line[1:0], col[1:0]}
   localparam logic [63:0] BAYER = 64'h5D7F91B36E4CA280;

   logic                       hs1, vs1, hs1_p, vs1_p;
   logic [2:0][IN_W-1:0]       pix1;
   logic [2:0][OUT_W-1:0]      q;
   logic [2:0]                 bar;
   logic [11:0]                col_q, col_cur, bcnt_q, bcnt_cur, bcnt_nxt;
   logic [10:0]                line_q, line_cur;
   logic [2:0]                 bidx_q, bidx_cur, bidx_nxt;
   logic                       h_ok_q, v_ok_q, hs_edge, vs_edge, active;
   logic [1:0]                 mode_q;
   logic [3:0]                 t;
   logic [IN_W-1:0]            dith;

   assign hs_edge = (hs1 ^ INACT) & ~(hs1_p ^ INACT);
   assign vs_edge = (vs1 ^ INACT) & ~(vs1_p ^ INACT);

   // Position of the pixel currently in stage 1; the registers hold last cycle's value
   always_comb begin
      col_cur  = hs_edge ? 12'd0 : ((col_q == 12'hFFF) ? col_q : col_q + 12'd1);
      line_cur = line_q;
      if (vs_edge)
         line_cur = 11'd0;
      else if (hs_edge && line_q != 11'h7FF)
         line_cur = line_q + 11'd1;
      // Position is trusted only once both syncs have been seen since reset
      active = (h_ok_q | hs_edge) & (v_ok_q | vs_edge) &
               (col_cur >= H_LO) & (col_cur < H_HI) &
               (line_cur >= V_LO) & (line_cur < V_HI);
      bcnt_cur = hs_edge ? 12'd0 : bcnt_q;
      bidx_cur = hs_edge ? 3'd0 : bidx_q;
      bcnt_nxt = bcnt_cur;
      bidx_nxt = bidx_cur;
      if (active) begin
         if (bcnt_cur == BAR_LAST) begin
            bcnt_nxt = 12'd0;
            bidx_nxt = bidx_cur + 3'd1;
         end else begin
            bcnt_nxt = bcnt_cur + 12'd1;
         end
      end
      t   = BAYER[{line_cur[1:0], col_cur[1:0]}*4 +: 4];
      bar = {~bidx_cur[0], ~bidx_cur[2], ~bidx_cur[1]};
   end

   generate
      if (D >= 4) begin : g_dshl
         logic [IN_W+3:0] t_wide;
         assign t_wide = (IN_W+4)'(t);
         assign dith   = IN_W'(t_wide << (D - 4));
      end else begin : g_dshr
         assign dith = IN_W'(t >> (4 - D));
      end

      for (genvar c = 0; c < 3; c++) begin : g_chan
         vga_dither_chan #(.IN_W(IN_W), .OUT_W(OUT_W)) u_chan (
            .mode (mode_q),
            .pix  (pix1[c]),
            .dith (dith),
            .bar  (bar[c]),
            .q    (q[c])
         );
      end
   endgenerate

   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         hs1    <= INACT;
         vs1    <= INACT;
         hs1_p  <= INACT;
         vs1_p  <= INACT;
         pix1   <= '0;
         col_q  <= '0;
         line_q <= '0;
         bcnt_q <= '0;
         bidx_q <= '0;
         h_ok_q <= 1'b0;
         v_ok_q <= 1'b0;
         mode_q <= 2'd0;
         VGA_HS <= INACT;
         VGA_VS <= INACT;
         VGA_R  <= '0;
         VGA_G  <= '0;
         VGA_B  <= '0;
      end else begin
         hs1    <= IN_HSYNC;
         vs1    <= IN_VSYNC;
         hs1_p  <= hs1;
         vs1_p  <= vs1;
         pix1   <= {IN_BLUE, IN_GREEN, IN_RED};
         col_q  <= col_cur;
         line_q <= line_cur;
         bcnt_q <= bcnt_nxt;
         bidx_q <= bidx_nxt;
         h_ok_q <= h_ok_q | hs_edge;
         v_ok_q <= v_ok_q | vs_edge;
         if (vs_edge)
            mode_q <= MODE;
         VGA_HS <= hs1;
         VGA_VS <= vs1;
         VGA_R  <= active ? q[0] : '0;
         VGA_G  <= active ? q[1] : '0;
         VGA_B  <= active ? q[2] : '0;
      end
   end
endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out on a shrunken 50x10 frame: vector table of constant-colour
// frames plus scoreboard of per-pixel expectations, with reset and mode-switch sequences.
module tb_vga_dither_out;
   localparam int HT = 50, VT = 10, HSW = 4, VSW = 2;
   localparam int HS0 = 10, HA = 32, VS0 = 3, VA = 4;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [1:0] mode_in = 2'd0;
   logic       hs_in = 1'b0, vs_in = 1'b0;
   logic [7:0] r_in = '0, g_in = '0, b_in = '0;
   logic       vga_hs, vga_vs;
   logic [3:0] vga_r, vga_g, vga_b;

   vga_dither_out #(.IN_W(8), .OUT_W(4), .SYNC_ACTIVE_LOW(1), .H_START(HS0),
                    .H_ACTIVE(HA), .V_START(VS0), .V_ACTIVE(VA)) dut (
      .CLK_25MHZ(clk), .RESET_N(rst_n), .MODE(mode_in),
      .IN_HSYNC(hs_in), .IN_VSYNC(vs_in),
      .IN_RED(r_in), .IN_GREEN(g_in), .IN_BLUE(b_in),
      .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b));

   always #5 clk = ~clk;

   typedef struct { logic [1:0] mode; logic [7:0] r, g, b; int er, eg, eb; } vec_t;
   typedef struct { logic hs, vs; logic [3:0] r, g, b; } exp_t;

   exp_t sb[$];
   vec_t vecs[5];
   int   checks = 0, failures = 0;
   int   bayer[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
   bit   frame_ok = 0;
   int   frame_mode = 0;

   function automatic int ref_chan(int m, int v, int th, int barbit);
      int s;
      case (m)
         0: return v / 16;
         1: begin s = (v + 8) / 16; return (s > 15) ? 15 : s; end
         2: begin s = (v + th) / 16; return (s > 15) ? 15 : s; end
         default: return barbit ? 15 : 0;
      endcase
   endfunction

   // Drive one pixel at frame position (x,y) and push what must emerge 2 cycles later
   task automatic pix(int x, int y, bit hs_a, bit vs_a, logic [1:0] m,
                      logic [7:0] r, logic [7:0] g, logic [7:0] b, int er, int eg, int eb);
      exp_t e;
      int th, i;
      bit act;
      @(posedge clk); #1;
      hs_in = ~hs_a; vs_in = ~vs_a; mode_in = m;
      r_in = r; g_in = g; b_in = b;
      if (vs_a && x == 0 && y == 0) begin
         frame_ok = 1;
         frame_mode = m;
      end
      act = frame_ok && x >= HS0 && x < HS0 + HA && y >= VS0 && y < VS0 + VA;
      th = bayer[(y % 4) * 4 + (x % 4)];
      i = (x - HS0) / (HA / 8);
      e.hs = ~hs_a; e.vs = ~vs_a;
      e.r = act ? 4'((er >= 0) ? er : ref_chan(frame_mode, r, th, ((i >> 1) & 1) == 0)) : 4'd0;
      e.g = act ? 4'((eg >= 0) ? eg : ref_chan(frame_mode, g, th, ((i >> 2) & 1) == 0)) : 4'd0;
      e.b = act ? 4'((eb >= 0) ? eb : ref_chan(frame_mode, b, th, (i & 1) == 0)) : 4'd0;
      sb.push_back(e);
   endtask

   task automatic run_frame(vec_t v, int sw_line, logic [1:0] sw_mode);
      logic [1:0] m;
      for (int y = 0; y < VT; y++)
         for (int x = 0; x < HT; x++) begin
            m = (y >= sw_line) ? sw_mode : v.mode;
            pix(x, y, x < HSW, y < VSW, m, v.r, v.g, v.b, v.er, v.eg, v.eb);
         end
   endtask

   task automatic check_rst(string name);
      checks++;
      if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_r !== 4'd0 || vga_g !== 4'd0 || vga_b !== 4'd0) begin
         failures++;
         $display("FAIL %s: got hs=%b vs=%b rgb=%h%h%h, want hs=1 vs=1 rgb=000",
                  name, vga_hs, vga_vs, vga_r, vga_g, vga_b);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 2) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (vga_hs !== e.hs || vga_vs !== e.vs || vga_r !== e.r || vga_g !== e.g || vga_b !== e.b) begin
            failures++;
            $display("FAIL sb @%0t: got hs=%b vs=%b rgb=%h%h%h, want hs=%b vs=%b rgb=%h%h%h",
                     $time, vga_hs, vga_vs, vga_r, vga_g, vga_b, e.hs, e.vs, e.r, e.g, e.b);
         end
      end
   end

   initial begin
      vecs[0] = '{2'd0, 8'hAB, 8'h17, 8'hF8, 4'hA, 1, 15};
      vecs[1] = '{2'd1, 8'h17, 8'h18, 8'hF8, 1, 2, 15};
      vecs[2] = '{2'd1, 8'h08, 8'h00, 8'hFF, 1, 0, 15};
      vecs[3] = '{2'd2, 8'h88, 8'hFF, 8'h00, -1, 15, 0};
      vecs[4] = '{2'd3, 8'hAB, 8'hAB, 8'hAB, -1, -1, -1};

      // Reset with syncs held asserted: outputs idle regardless
      repeat (3) @(negedge clk);
      check_rst("reset_hold");
      @(posedge clk); #1;
      hs_in = 1'b1; vs_in = 1'b1; mode_in = 2'd1; r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk) check_rst("reset_release");

      // Idle, then HS-only lines: no VS seen yet, so everything stays blanked
      for (int k = 0; k < 20; k++) pix(HT - 1, VT - 1, 0, 0, 2'd1, 8'hFF, 8'hFF, 8'hFF, -1, -1, -1);
      for (int y = 3; y < 8; y++)
         for (int x = 0; x < HT; x++) pix(x, y, x < HSW, 0, 2'd1, 8'hFF, 8'hFF, 8'hFF, -1, -1, -1);

      foreach (vecs[n]) run_frame(vecs[n], VT, vecs[n].mode);

      // Mid-frame MODE change only lands at the next VS edge
      run_frame(vecs[0], 4, 2'd3);
      run_frame('{2'd3, 8'hAB, 8'hAB, 8'hAB, -1, -1, -1}, VT, 2'd3);

      // Reset mid-frame clears outputs at once
      for (int y = 0; y < VT && !(y == 5); y++)
         for (int x = 0; x < HT; x++) pix(x, y, x < HSW, y < VSW, 2'd2, 8'h88, 8'h88, 8'h88, -1, -1, -1);
      for (int x = 0; x < 20; x++) pix(x, 5, x < HSW, 0, 2'd2, 8'h88, 8'h88, 8'h88, -1, -1, -1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      sb.delete();
      frame_ok = 0;
      #1 check_rst("reset_midframe");
      hs_in = 1'b1; vs_in = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) pix(HT - 1, VT - 1, 0, 0, 2'd1, 8'hFF, 8'hFF, 8'hFF, -1, -1, -1);
      run_frame(vecs[1], VT, vecs[1].mode);
      for (int k = 0; k < 4; k++) pix(HT - 1, VT - 1, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, -1, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
